// File: rtl/inference_feeder.sv
// Feed-side sequencer: fetches samples, drives the layer pipeline, and scores
// returned class vectors into running count/correct/accuracy figures.
module inference_feeder #(
  parameter int datawidth   = 8,
  parameter int num_inputs  = 64,
  parameter int num_classes = 10,
  parameter int label_width = 4,
  parameter int max_inputs  = 200,
  parameter int cw          = $clog2(max_inputs + 1)
) (
  input  logic                              clk,
  input  logic                              rst_overall,
  input  logic                              enable_inference,
  output logic                              mem_rd_en,
  output logic [$clog2(max_inputs)-1:0]     mem_addr,
  input  logic [num_inputs*datawidth-1:0]   mem_rdata,
  input  logic [label_width-1:0]            mem_label,
  output logic [num_inputs*datawidth-1:0]   input_values,
  output logic                              input_loaded,
  input  logic                              complete,
  input  logic [num_classes-1:0]            obtained_output,
  output logic [num_classes-1:0]            expected_output,
  output logic                              begin_next,
  output logic [cw-1:0]                     count,
  output logic [cw-1:0]                     correct,
  output logic [8:0]                        accuracy,
  output logic                              all_done
);
  localparam int AW = $clog2(max_inputs);
  localparam int NW = 16;

  typedef enum logic [3:0] {IDLE, FETCH, CAPTURE, LOAD, RUN, SCORE, DIV, NEXT, DONE} state_t;
  state_t state;

  logic [num_classes-1:0] obtained_q, onehot;
  logic                   label_ok, hit, ge;
  logic [4:0]             div_cnt;
  logic [NW-1:0]          quot, q_next;
  logic [cw:0]            rem, r_next;
  logic [cw+1:0]          trial;
  logic [cw-1:0]          correct_n;

  // Out-of-range labels decode to an all-zero vector.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < num_classes; i++)
      if (32'(mem_label) == i) onehot[i] = 1'b1;
  end

  // One restoring shift-subtract step; divisor is the already-updated count.
  always_comb begin
    trial  = {rem, quot[NW-1]};
    ge     = trial >= {2'b00, count};
    q_next = {quot[NW-2:0], ge};
    r_next = ge ? (cw+1)'(trial - {2'b00, count}) : trial[cw:0];
  end

  assign correct_n = correct + cw'(hit);

  always_ff @(posedge clk or posedge rst_overall) begin
    if (rst_overall) begin
      state           <= IDLE;
      mem_rd_en       <= 1'b0;
      mem_addr        <= '0;
      input_values    <= '0;
      input_loaded    <= 1'b0;
      expected_output <= '0;
      begin_next      <= 1'b0;
      count           <= '0;
      correct         <= '0;
      accuracy        <= '0;
      all_done        <= 1'b0;
      obtained_q      <= '0;
      label_ok        <= 1'b0;
      hit             <= 1'b0;
      div_cnt         <= '0;
      quot            <= '0;
      rem             <= '0;
    end else begin
      mem_rd_en    <= 1'b0;
      input_loaded <= 1'b0;
      begin_next   <= 1'b0;
      case (state)
        IDLE: if (enable_inference) begin
          state     <= FETCH;
          mem_rd_en <= 1'b1;
          mem_addr  <= AW'(count);
        end
        FETCH: state <= CAPTURE;
        CAPTURE: begin
          input_values    <= mem_rdata;
          expected_output <= onehot;
          label_ok        <= 32'(mem_label) < num_classes;
          input_loaded    <= 1'b1;
          state           <= LOAD;
        end
        LOAD: state <= RUN;
        RUN: if (complete) begin
          obtained_q <= obtained_output;
          state      <= SCORE;
        end
        SCORE: begin
          hit     <= label_ok && (obtained_q == expected_output);
          div_cnt <= '0;
          state   <= DIV;
        end
        // First DIV cycle commits the counts and seeds the divider; 16 steps follow.
        DIV: begin
          if (div_cnt == 5'd0) begin
            count   <= count + cw'(1);
            correct <= correct_n;
            quot    <= NW'(correct_n) * NW'(100);
            rem     <= '0;
            div_cnt <= 5'd1;
          end else begin
            quot    <= q_next;
            rem     <= r_next;
            div_cnt <= div_cnt + 5'd1;
            if (div_cnt == 5'd16) begin
              accuracy   <= 9'(q_next);
              begin_next <= 1'b1;
              state      <= NEXT;
            end
          end
        end
        NEXT: begin
          if (count == cw'(max_inputs)) begin
            state    <= DONE;
            all_done <= 1'b1;
          end else if (!enable_inference) begin
            state <= IDLE;
          end else begin
            state     <= FETCH;
            mem_rd_en <= 1'b1;
            mem_addr  <= AW'(count);
          end
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inference_feeder.sv
// Randomized bench for inference_feeder: memory and pipeline modelled here,
// scores checked against a count/correct/percentage reference model.
module tb_inference_feeder;
  localparam int DW = 8, NI = 64, NC = 10, LW = 4, MI = 4;
  localparam int CW = $clog2(MI + 1), AW = $clog2(MI), VW = DW * NI;

  logic          clk = 1'b0;
  logic          rst_overall, enable_inference, mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [VW-1:0] mem_rdata, input_values;
  logic [LW-1:0] mem_label;
  logic          input_loaded, complete, begin_next, all_done;
  logic [NC-1:0] obtained_output, expected_output;
  logic [CW-1:0] count, correct;
  logic [8:0]    accuracy;

  int n_cmp = 0, n_err = 0;
  int m_count, m_correct;
  logic [VW-1:0] mem_vec [MI];
  logic [LW-1:0] mem_lab [MI];

  inference_feeder #(.datawidth(DW), .num_inputs(NI), .num_classes(NC),
                     .label_width(LW), .max_inputs(MI)) dut (
    .clk(clk), .rst_overall(rst_overall), .enable_inference(enable_inference),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_label(mem_label), .input_values(input_values), .input_loaded(input_loaded),
    .complete(complete), .obtained_output(obtained_output),
    .expected_output(expected_output), .begin_next(begin_next), .count(count),
    .correct(correct), .accuracy(accuracy), .all_done(all_done));

  always #5 clk = ~clk;

  // Sample store: data appears one cycle after the strobe.
  always @(posedge clk)
    if (mem_rd_en) begin
      mem_rdata <= mem_vec[mem_addr];
      mem_label <= mem_lab[mem_addr];
    end

  function automatic logic [NC-1:0] onehot(input logic [LW-1:0] l);
    if (int'(l) < NC) return NC'(1) << l;
    return '0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    enable_inference = 1'b0;
    complete = 1'b0;
    rst_overall = 1'b1;
    repeat (2) @(negedge clk);
    rst_overall = 1'b0;
    m_count = 0;
    m_correct = 0;
  endtask

  task automatic fill_vectors();
    for (int i = 0; i < MI; i++)
      for (int w = 0; w < VW / 32; w++) mem_vec[i][w*32 +: 32] = $urandom();
  endtask

  // One full sample: waits for the load pulse, answers after d cycles, checks scoring.
  task automatic run_sample(input logic [NC-1:0] obt, input int d, input bit drop_en,
                            input bit load_glitch);
    int  addr, lat;
    bit  seen, bad;
    addr = m_count;
    seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (input_loaded) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      $display("FAIL load_timeout: no input_loaded for sample %0d", addr);
      n_err++;
      return;
    end
    n_cmp++;
    if (input_values !== mem_vec[addr]) begin
      $display("FAIL input_values: sample %0d got %h expected %h", addr, input_values, mem_vec[addr]);
      n_err++;
    end
    n_cmp++;
    if (expected_output !== onehot(mem_lab[addr])) begin
      $display("FAIL expected_output: got %b expected %b", expected_output, onehot(mem_lab[addr]));
      n_err++;
    end
    if (drop_en) enable_inference = 1'b0;
    if (load_glitch) begin
      complete = 1'b1;
      obtained_output = obt;
      @(negedge clk);
      complete = 1'b0;
      bad = 0;
      repeat (20) begin
        @(negedge clk);
        if (begin_next || count !== CW'(m_count)) bad = 1;
      end
      n_cmp++;
      if (bad) begin
        $display("FAIL load_glitch: complete during LOAD was acted on (count %0d)", count);
        n_err++;
      end
    end
    repeat (d) @(negedge clk);
    complete = 1'b1;
    obtained_output = obt;
    @(negedge clk);
    complete = 1'b0;
    obtained_output = NC'($urandom);
    m_count++;
    if (int'(mem_lab[addr]) < NC && obt == onehot(mem_lab[addr])) m_correct++;
    seen = 0;
    lat = 0;
    for (int j = 1; j <= 40 && !seen; j++) begin
      @(negedge clk);
      if (j == 2) begin
        n_cmp++;
        if (count !== CW'(m_count) || correct !== CW'(m_correct)) begin
          $display("FAIL counts: got %0d/%0d expected %0d/%0d", correct, count, m_correct, m_count);
          n_err++;
        end
      end
      if (begin_next) begin
        seen = 1;
        lat = j;
      end
    end
    n_cmp++;
    if (lat != 18) begin
      $display("FAIL begin_next_latency: got %0d expected 18", lat);
      n_err++;
    end
    n_cmp++;
    if (accuracy !== 9'(m_correct * 100 / m_count)) begin
      $display("FAIL accuracy: got %0d expected %0d", accuracy, m_correct * 100 / m_count);
      n_err++;
    end
    @(negedge clk);
    n_cmp++;
    if (begin_next !== 1'b0) begin
      $display("FAIL begin_next_width: still high, expected 0");
      n_err++;
    end
    if (enable_inference && m_count < MI) begin
      n_cmp++;
      if (mem_rd_en !== 1'b1 || mem_addr !== AW'(m_count)) begin
        $display("FAIL next_fetch: rd_en %b addr %0d expected 1 addr %0d", mem_rd_en, mem_addr, m_count);
        n_err++;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({mem_rd_en, mem_addr, input_values, input_loaded, expected_output, begin_next,
         count, correct, accuracy, all_done} !== '0) begin
      $display("FAIL reset_values: outputs not all zero (count %0d acc %0d)", count, accuracy);
      n_err++;
    end
  endtask

  task automatic test_scoring();
    bit bad;
    do_reset();
    fill_vectors();
    mem_lab[0] = 4'd3; mem_lab[1] = 4'd7; mem_lab[2] = 4'd5; mem_lab[3] = 4'd1;
    enable_inference = 1'b1;
    run_sample(10'b0000001000, 1, 0, 0);
    n_cmp++;
    if (expected_output !== 10'b0000001000 || accuracy !== 9'd100) begin
      $display("FAIL single_match: exp %b acc %0d expected 0000001000 acc 100", expected_output, accuracy);
      n_err++;
    end
    run_sample(10'b0000000001, 3, 0, 0);
    n_cmp++;
    if (accuracy !== 9'd50) begin
      $display("FAIL mismatch_acc: got %0d expected 50", accuracy);
      n_err++;
    end
    run_sample(onehot(4'd5), 1, 0, 0);
    n_cmp++;
    if (accuracy !== 9'd66) begin
      $display("FAIL floor_acc: got %0d expected 66", accuracy);
      n_err++;
    end
    run_sample(onehot(4'd1), 2, 0, 0);
    n_cmp++;
    if (accuracy !== 9'd75 || all_done !== 1'b1) begin
      $display("FAIL full_run: acc %0d done %b expected 75 1", accuracy, all_done);
      n_err++;
    end
    bad = 0;
    for (int j = 0; j < 30; j++) begin
      complete = (j % 3 == 0);
      obtained_output = NC'($urandom);
      @(negedge clk);
      if (mem_rd_en || begin_next || !all_done || count !== CW'(4) || accuracy !== 9'd75) bad = 1;
    end
    complete = 1'b0;
    n_cmp++;
    if (bad) begin
      $display("FAIL done_hold: activity after done (count %0d acc %0d)", count, accuracy);
      n_err++;
    end
  endtask

  task automatic test_pause_and_reset();
    bit bad, seen;
    do_reset();
    fill_vectors();
    for (int i = 0; i < MI; i++) mem_lab[i] = LW'($urandom_range(0, 9));
    enable_inference = 1'b1;
    run_sample(onehot(mem_lab[0]), 1, 0, 0);
    run_sample(NC'($urandom), 2, 1, 0);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_rd_en) bad = 1;
    end
    n_cmp++;
    if (bad || count !== CW'(2)) begin
      $display("FAIL pause: fetched while paused or count %0d expected 2", count);
      n_err++;
    end
    enable_inference = 1'b1;
    seen = 0;
    for (int k = 0; k < 5 && !seen; k++) begin
      @(negedge clk);
      if (mem_rd_en) seen = 1;
    end
    n_cmp++;
    if (!seen || mem_addr !== AW'(2)) begin
      $display("FAIL resume_addr: seen %b addr %0d expected addr 2", seen, mem_addr);
      n_err++;
    end
    // Reset while waiting in RUN for sample 2.
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (input_loaded) seen = 1;
    end
    @(negedge clk);
    rst_overall = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({mem_rd_en, mem_addr, input_values, input_loaded, expected_output, begin_next,
         count, correct, accuracy, all_done} !== '0) begin
      $display("FAIL midrun_reset: count %0d acc %0d loaded %b expected all zero", count, accuracy, input_loaded);
      n_err++;
    end
    rst_overall = 1'b0;
    enable_inference = 1'b1;
    seen = 0;
    for (int k = 0; k < 5 && !seen; k++) begin
      @(negedge clk);
      if (mem_rd_en) seen = 1;
    end
    n_cmp++;
    if (!seen || mem_addr !== '0) begin
      $display("FAIL restart_addr: seen %b addr %0d expected addr 0", seen, mem_addr);
      n_err++;
    end
  endtask

  task automatic test_invalid_label();
    do_reset();
    fill_vectors();
    mem_lab[0] = 4'd12;
    enable_inference = 1'b1;
    run_sample('0, 2, 0, 1);
    n_cmp++;
    if (expected_output !== '0 || correct !== '0 || count !== CW'(1)) begin
      $display("FAIL invalid_label: exp %b correct %0d count %0d expected 0 0 1", expected_output, correct, count);
      n_err++;
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      do_reset();
      fill_vectors();
      for (int i = 0; i < MI; i++) mem_lab[i] = LW'($urandom_range(0, 15));
      enable_inference = 1'b1;
      for (int i = 0; i < MI; i++)
        run_sample($urandom_range(0, 1) ? onehot(mem_lab[i]) : NC'($urandom),
                   $urandom_range(1, 6), 0, 0);
      n_cmp++;
      if (all_done !== 1'b1) begin
        $display("FAIL random_done: all_done %b expected 1", all_done);
        n_err++;
      end
    end
  endtask

  initial begin
    rst_overall = 1'b1;
    enable_inference = 1'b0;
    complete = 1'b0;
    obtained_output = '0;
    mem_rdata = '0;
    mem_label = '0;
    test_reset();
    rst_overall = 1'b0;
    test_scoring();
    test_pause_and_reset();
    test_invalid_label();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/inference_feeder.md
# inference_feeder

Sequencer that drives the inference datapath with test samples and scores its results. Fetches one sample (input vector plus class label) per iteration from an external sample memory, presents it to the layer pipeline with a load pulse, and waits for the pipeline's completion pulse. It then compares the returned class vector against the one-hot label, keeps running correct/total counts with an integer accuracy percentage, and pulses `begin_next` before fetching the following sample. Sits between the sample store and the layer pipeline, on the feed side of the interface whose result side the top-level monitors.

## Interface
- `datawidth`, 8, bits per input element
- `num_inputs`, 64, elements per input vector (layer-0 columns)
- `num_classes`, 10, output classes (last-layer rows)
- `label_width`, 4, label bits
- `max_inputs`, 200, samples per run
- `cw`, $clog2(max_inputs+1), count width
- `clk` in 1: single clock, rising edge
- `rst_overall` in 1: reset, asynchronous, active-high
- `enable_inference` in 1: run enable (level)
- `mem_rd_en` out 1: sample memory read strobe
- `mem_addr` out $clog2(max_inputs): sample index
- `mem_rdata` in num_inputs*datawidth: input vector, valid 1 cycle after strobe
- `mem_label` in label_width: label, valid with `mem_rdata`
- `input_values` out num_inputs*datawidth: registered vector to layer 0
- `input_loaded` out 1: one-cycle load pulse to pipeline
- `complete` in 1: pipeline done pulse
- `obtained_output` in num_classes: pipeline class vector, valid with `complete`
- `expected_output` out num_classes: one-hot label
- `begin_next` out 1: one-cycle end-of-sample pulse
- `count` out cw: samples scored
- `correct` out cw: samples matched
- `accuracy` out 9: floor(correct*100/count), 0..100
- `all_done` out 1: run finished, sticky

## Operation
- States: IDLE, FETCH, CAPTURE, LOAD, RUN, SCORE, DIV, NEXT, DONE.
- IDLE: `enable_inference`=1 -> FETCH, otherwise stay.
- FETCH: `mem_rd_en`=1, `mem_addr`=`count`. Next state is CAPTURE.
- CAPTURE: register `mem_rdata` into `input_values`. Register the label into `expected_output` as bit[label]=1. If label >= num_classes, `expected_output` is all zeros. Next state is LOAD.
- LOAD: `input_loaded`=1 for one cycle. Next state is RUN.
- RUN: wait for `complete`. Register `obtained_output` on the edge where `complete`=1. Next state is SCORE.
- SCORE: `count`+=1. If label < num_classes and `obtained_output`==`expected_output`, `correct`+=1. Next state is DIV.
- DIV: restoring shift-subtract division of correct*100 (16-bit numerator) by count. Lasts exactly 16 cycles. Result loads into `accuracy` on the last cycle. count>=1 always holds here. Next state is NEXT.
- NEXT: `begin_next`=1 for one cycle. Then:
  - `count`==max_inputs -> DONE;
  - `enable_inference`=0 -> IDLE (resumes at address `count`);
  - otherwise -> FETCH.
- DONE: `all_done`=1. No further memory reads. Held until reset.
- `complete` outside RUN is ignored. `enable_inference` is sampled only in IDLE and NEXT; dropping it mid-sample does not abort that sample.
- `input_values`, `expected_output` and `accuracy` hold their values between updates.

## Timing
- Reset (asynchronous, any state):
  - state=IDLE;
  - all outputs 0: `mem_rd_en`, `mem_addr`, `input_values`, `input_loaded`, `expected_output`, `begin_next`, `count`, `correct`, `accuracy`, `all_done`.
  - Reset mid-run discards the sample in flight; the next run restarts at address 0.
- `enable_inference` sampled high in IDLE at edge E0:
  - `mem_rd_en` is high during cycle E0..E1;
  - data is captured at E2;
  - `input_loaded` is high during E2..E3.
- `complete` sampled at edge C:
  - `count` and `correct` updated at C+2;
  - `accuracy` valid at C+18;
  - `begin_next` high during C+18..C+19.
- NEXT -> FETCH: the next `mem_rd_en` follows `begin_next` immediately.
- Minimum iteration, load pulse to next load pulse with `complete` one cycle after load: 23 cycles.
- All outputs are registered. There are no combinational input-to-output paths.

## Test plan
- Reset values: assert `rst_overall` mid-RUN -> all outputs 0 on the next sample instant. After release with enable=1, the first `mem_addr` is 0.
- Single match: label 3; return `obtained_output`=0000001000 with `complete` two cycles after `input_loaded` -> `expected_output`=0000001000, `count`=1, `correct`=1, `accuracy`=100, one `begin_next` pulse exactly 18 cycles after the `complete` edge.
- Mismatch: second sample label 7, obtained 0000000001 -> `count`=2, `correct`=1, `accuracy`=50. Third sample correct -> `accuracy`=66 (floor).
- Full run with max_inputs=4, three correct -> `accuracy`=75, `all_done`=1 after the fourth `begin_next`. No `mem_rd_en` afterwards. Spurious `complete` pulses change nothing.
- Pause/resume: drop enable during RUN of sample 1 -> sample 1 finishes and scores, then IDLE. Reassert after 10 cycles -> `mem_addr`=2.
- Invalid label 12 with obtained 0 -> `expected_output`=0, counted incorrect. `complete` pulsed during LOAD -> ignored; the FSM waits in RUN.
